// File: rtl/enc_code_lock_ctrl.sv
// Digit-code lock sequencer driven by encoder position and pushbutton press events.
// Handles code entry/verify, unlock with auto-relock, re-programming and failure lockout.
module enc_code_lock_ctrl #(
  parameter int unsigned             CODE_LEN       = 4,
  parameter int unsigned             MAX_FAILS      = 3,
  parameter int unsigned             LOCKOUT_CYCLES = 1024,
  parameter int unsigned             UNLOCK_CYCLES  = 4096,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] enc,
  input  logic [1:0] pb_press_type,
  output logic       unlocked,
  output logic       lockout,
  output logic       prog_mode,
  output logic [1:0] digit_idx,
  output logic [2:0] fail_cnt,
  output logic       ok_pulse,
  output logic       err_pulse
);

  localparam int unsigned TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned CW   = 4 * CODE_LEN;

  localparam logic [1:0]    LAST_IDX    = 2'(CODE_LEN - 1);
  localparam logic [2:0]    MAX_F       = 3'(MAX_FAILS);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_UNLOCKED,
    S_PROGRAM,
    S_LOCKOUT
  } state_t;

  state_t          r_state, w_state_nx;
  logic [CW-1:0]   r_code, w_code_nx;
  logic [CW-1:0]   r_shadow, w_shadow_nx;
  logic [1:0]      r_digit_idx, w_idx_nx;
  logic            r_mismatch, w_mis_nx;
  logic [2:0]      r_fail_cnt, w_fail_nx;
  logic [TW-1:0]   r_timer, w_timer_nx;
  logic            r_ok, w_ok_nx;
  logic            r_err, w_err_nx;

  logic            w_short, w_long;
  logic [3:0]      w_stored;
  logic [CW-1:0]   w_shadow_wr;
  logic [2:0]      w_fail_inc;

  assign w_short    = (pb_press_type == 2'b01);
  assign w_long     = (pb_press_type == 2'b10);
  assign w_fail_inc = (r_fail_cnt >= MAX_F) ? MAX_F : r_fail_cnt + 3'd1;

  // Digit select / shadow write-merge; the merged value is what gets committed on the last digit.
  always_comb begin
    w_stored    = '0;
    w_shadow_wr = r_shadow;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (r_digit_idx == 2'(i)) begin
        w_stored            = r_code[i*4 +: 4];
        w_shadow_wr[i*4 +: 4] = enc;
      end
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_code_nx   = r_code;
    w_shadow_nx = r_shadow;
    w_idx_nx    = r_digit_idx;
    w_mis_nx    = r_mismatch;
    w_fail_nx   = r_fail_cnt;
    w_timer_nx  = r_timer;
    w_ok_nx     = 1'b0;
    w_err_nx    = 1'b0;
    case (r_state)
      S_ENTRY: begin
        if (w_short) begin
          w_mis_nx = r_mismatch | (enc != w_stored);
          if (r_digit_idx == LAST_IDX) begin
            w_state_nx = S_CHECK;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_digit_idx + 2'd1;
          end
        end else if (w_long) begin
          w_idx_nx = '0;
          w_mis_nx = 1'b0;
        end
      end
      S_CHECK: begin
        w_mis_nx = 1'b0;
        if (!r_mismatch) begin
          w_ok_nx    = 1'b1;
          w_fail_nx  = '0;
          w_state_nx = S_UNLOCKED;
          w_timer_nx = UNLOCK_LOAD;
        end else begin
          w_err_nx  = 1'b1;
          w_fail_nx = w_fail_inc;
          if (w_fail_inc == MAX_F) begin
            w_state_nx = S_LOCKOUT;
            w_timer_nx = LOCK_LOAD;
          end else begin
            w_state_nx = S_ENTRY;
          end
        end
      end
      S_UNLOCKED: begin
        // Expiry takes priority over a press landing on the same edge.
        if (r_timer == '0) begin
          w_state_nx = S_ENTRY;
        end else begin
          w_timer_nx = r_timer - TW'(1);
          if (w_short) begin
            w_state_nx = S_ENTRY;
          end else if (w_long) begin
            w_state_nx = S_PROGRAM;
            w_idx_nx   = '0;
          end
        end
      end
      S_PROGRAM: begin
        if (w_short) begin
          w_shadow_nx = w_shadow_wr;
          if (r_digit_idx == LAST_IDX) begin
            w_code_nx  = w_shadow_wr;
            w_state_nx = S_UNLOCKED;
            w_timer_nx = UNLOCK_LOAD;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_digit_idx + 2'd1;
          end
        end else if (w_long) begin
          w_state_nx = S_UNLOCKED;
          w_timer_nx = UNLOCK_LOAD;
          w_idx_nx   = '0;
        end
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_fail_nx  = '0;
          w_state_nx = S_ENTRY;
        end else begin
          w_timer_nx = r_timer - TW'(1);
        end
      end
      default: w_state_nx = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_ENTRY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_code      <= DEFAULT_CODE;
      r_shadow    <= '0;
      r_digit_idx <= '0;
      r_mismatch  <= 1'b0;
      r_fail_cnt  <= '0;
      r_timer     <= '0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_code      <= w_code_nx;
      r_shadow    <= w_shadow_nx;
      r_digit_idx <= w_idx_nx;
      r_mismatch  <= w_mis_nx;
      r_fail_cnt  <= w_fail_nx;
      r_timer     <= w_timer_nx;
      r_ok        <= w_ok_nx;
      r_err       <= w_err_nx;
    end
  end

  assign unlocked  = (r_state == S_UNLOCKED) || (r_state == S_PROGRAM);
  assign lockout   = (r_state == S_LOCKOUT);
  assign prog_mode = (r_state == S_PROGRAM);
  assign digit_idx = r_digit_idx;
  assign fail_cnt  = r_fail_cnt;
  assign ok_pulse  = r_ok;
  assign err_pulse = r_err;

endmodule

// File: tb/tb_enc_code_lock_ctrl.sv
// Directed bench for enc_code_lock_ctrl: entry, failures/lockout, program, abort, timeout, reset.
module tb_enc_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] enc = '0;
  logic [1:0] pb_press_type = '0;
  logic       unlocked, lockout, prog_mode, ok_pulse, err_pulse;
  logic [1:0] digit_idx;
  logic [2:0] fail_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n;

  localparam logic [1:0] SHORT = 2'b01;
  localparam logic [1:0] LONG  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  enc_code_lock_ctrl #(
    .CODE_LEN(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(1024),
    .UNLOCK_CYCLES(4096), .DEFAULT_CODE(16'h1234)
  ) dut (
    .clk(clk), .rstn(rstn), .enc(enc), .pb_press_type(pb_press_type),
    .unlocked(unlocked), .lockout(lockout), .prog_mode(prog_mode),
    .digit_idx(digit_idx), .fail_cnt(fail_cnt),
    .ok_pulse(ok_pulse), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One press event spanning exactly one rising edge; returns 1 time unit after that edge.
  task automatic press(input logic [3:0] e, input logic [1:0] t);
    @(negedge clk);
    enc = e;
    pb_press_type = t;
    @(posedge clk);
    #1;
    pb_press_type = 2'b00;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic enter4(input logic [3:0] d0, input logic [3:0] d1,
                        input logic [3:0] d2, input logic [3:0] d3);
    press(d0, SHORT);
    press(d1, SHORT);
    press(d2, SHORT);
    press(d3, SHORT);
  endtask

  initial begin
    #23;
    check("rst_unlocked", 16'(unlocked), 16'd0);
    check("rst_lockout", 16'(lockout), 16'd0);
    check("rst_prog", 16'(prog_mode), 16'd0);
    check("rst_idx", 16'(digit_idx), 16'd0);
    check("rst_fail", 16'(fail_cnt), 16'd0);
    check("rst_pulses", 16'({ok_pulse, err_pulse}), 16'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Default code, digits 4,3,2,1; reserved press is a no-op
    press(4'd7, RSVD);
    check("rsvd_idx", 16'(digit_idx), 16'd0);
    press(4'd4, SHORT);
    check("idx_after_1", 16'(digit_idx), 16'd1);
    press(4'd3, SHORT);
    press(4'd2, SHORT);
    check("idx_after_3", 16'(digit_idx), 16'd3);
    press(4'd1, SHORT);
    check("check_idx0", 16'(digit_idx), 16'd0);
    check("check_no_ok_yet", 16'(ok_pulse), 16'd0);
    idle(1);
    check("ok_pulse", 16'(ok_pulse), 16'd1);
    check("unlocked", 16'(unlocked), 16'd1);
    check("fail_after_ok", 16'(fail_cnt), 16'd0);
    idle(1);
    check("ok_one_cycle", 16'(ok_pulse), 16'd0);
    press(4'd0, RSVD);
    check("rsvd_unlocked", 16'(unlocked), 16'd1);
    press(4'd0, SHORT);
    check("manual_relock", 16'(unlocked), 16'd0);

    // Three wrong codes -> lockout
    enter4(4'd4, 4'd3, 4'd2, 4'd0);
    idle(1);
    check("err1_pulse", 16'(err_pulse), 16'd1);
    check("err1_fail", 16'(fail_cnt), 16'd1);
    check("err1_locked", 16'({unlocked, lockout}), 16'd0);
    enter4(4'd4, 4'd3, 4'd2, 4'd0);
    idle(1);
    check("err2_fail", 16'(fail_cnt), 16'd2);
    enter4(4'd4, 4'd3, 4'd2, 4'd0);
    idle(1);
    check("err3_pulse", 16'(err_pulse), 16'd1);
    check("err3_fail", 16'(fail_cnt), 16'd3);
    check("lockout_rise", 16'(lockout), 16'd1);
    n = 1;
    press(4'd4, SHORT);
    if (lockout) n++;
    check("lock_ignores_short", 16'(digit_idx), 16'd0);
    press(4'd4, LONG);
    if (lockout) n++;
    check("lock_ignores_long", 16'({unlocked, prog_mode}), 16'd0);
    check("lock_fail_held", 16'(fail_cnt), 16'd3);
    while (lockout && n < 1100) begin
      @(posedge clk);
      #1;
      if (lockout) n++;
    end
    check("lockout_len", 16'(n), 16'd1024);
    check("lockout_fell", 16'(lockout), 16'd0);
    check("lockout_fail_clr", 16'(fail_cnt), 16'd0);

    // Partial entry cleared by long press
    press(4'd4, SHORT);
    press(4'd3, SHORT);
    press(4'd0, LONG);
    check("long_clears_idx", 16'(digit_idx), 16'd0);
    enter4(4'd4, 4'd3, 4'd2, 4'd1);
    idle(1);
    check("after_clear_ok", 16'(ok_pulse), 16'd1);

    // Reprogram to 9,8,7,6
    press(4'd0, LONG);
    check("prog_mode", 16'({unlocked, prog_mode}), 16'h3);
    press(4'd9, SHORT);
    press(4'd8, SHORT);
    press(4'd7, SHORT);
    check("prog_idx3", 16'(digit_idx), 16'd3);
    press(4'd6, SHORT);
    check("prog_commit", 16'({unlocked, prog_mode}), 16'h2);
    check("prog_idx0", 16'(digit_idx), 16'd0);
    press(4'd0, SHORT);
    check("relock2", 16'(unlocked), 16'd0);
    enter4(4'd4, 4'd3, 4'd2, 4'd1);
    idle(1);
    check("old_code_err", 16'(err_pulse), 16'd1);
    check("old_code_fail", 16'(fail_cnt), 16'd1);
    enter4(4'd9, 4'd8, 4'd7, 4'd6);
    idle(1);
    check("new_code_ok", 16'(ok_pulse), 16'd1);
    check("new_code_fail0", 16'(fail_cnt), 16'd0);

    // Reset mid-program restores the default code
    press(4'd0, LONG);
    press(4'd5, SHORT);
    press(4'd5, SHORT);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_outs", 16'({unlocked, lockout, prog_mode, digit_idx, fail_cnt, ok_pulse, err_pulse}), 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    enter4(4'd4, 4'd3, 4'd2, 4'd1);
    idle(1);
    check("default_restored", 16'(ok_pulse), 16'd1);

    // Aborted program leaves code unchanged (digit 0 entered too)
    press(4'd0, LONG);
    press(4'd5, SHORT);
    press(4'd0, SHORT);
    press(4'd0, LONG);
    check("abort_state", 16'({unlocked, prog_mode, digit_idx}), 16'h8);
    press(4'd0, SHORT);
    enter4(4'd4, 4'd3, 4'd2, 4'd1);
    idle(1);
    check("abort_code_kept", 16'(ok_pulse), 16'd1);

    // Auto-relock timeout: unlocked for exactly 4096 cycles
    n = 1;
    while (unlocked && n < 4200) begin
      @(posedge clk);
      #1;
      if (unlocked) n++;
    end
    check("unlock_len", 16'(n), 16'd4096);
    check("timeout_relock", 16'(unlocked), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_code_lock_ctrl.md
Name: enc_code_lock_ctrl

Overview:
- Sequencer that consumes the rotational encoder's 4-bit position and its pushbutton press events.
- Implements a digit-code lock: the user dials a value and confirms each digit with a short press.
- Includes verify, unlock, re-program and failure-lockout phases.
- Sits between the rotational encoder instance and the top-level status outputs.

Parameters:
- CODE_LEN, 4: number of 4-bit digits per code (2..4).
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout (1..7).
- LOCKOUT_CYCLES, 1024: lockout duration in clk cycles.
- UNLOCK_CYCLES, 4096: auto-relock timeout in clk cycles.
- DEFAULT_CODE, 16'h1234: code loaded at reset; digit 0 in bits [3:0]; width 4*CODE_LEN.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enc  in  4  current encoder count (digit value 0..15)
- pb_press_type  in  2  one-cycle press event: 00 none, 01 short, 10 long, 11 reserved (ignored)
- unlocked  out  1  high while in UNLOCKED or PROGRAM
- lockout  out  1  high while in LOCKOUT
- prog_mode  out  1  high while in PROGRAM
- digit_idx  out  2  index of the next digit to be entered
- fail_cnt  out  3  consecutive failed attempts
- ok_pulse  out  1  one-cycle pulse on a correct code
- err_pulse  out  1  one-cycle pulse on a wrong code

Behaviour:
- Reset (async, rstn=0):
  - state=ENTRY; code register=DEFAULT_CODE; digit_idx=0; mismatch flag=0; fail_cnt=0; timers=0.
  - All outputs 0.
- Timing:
  - Events are sampled on the rising clk edge where pb_press_type != 00.
  - Effects are visible on registered outputs the following cycle.
  - pb_press_type=11 is a no-op in every state.
- ENTRY:
  - Short press: compare enc with stored digit[digit_idx]; OR any inequality into the mismatch flag; digit_idx++.
  - If digit_idx==CODE_LEN-1 at the press, go to CHECK instead and reset digit_idx to 0.
  - Long press: digit_idx=0, mismatch=0; stay in ENTRY.
- CHECK (exactly one cycle, presses ignored):
  - mismatch=0: ok_pulse=1; fail_cnt=0; go to UNLOCKED; load the unlock timer.
  - mismatch=1: err_pulse=1; fail_cnt++.
    - If the new fail_cnt==MAX_FAILS, go to LOCKOUT and load the lockout timer.
    - Otherwise go to ENTRY.
  - mismatch is cleared on exit in both cases.
- UNLOCKED:
  - Timer decrements each cycle; at 0, go to ENTRY.
  - Short press: go to ENTRY (manual relock).
  - Long press: go to PROGRAM with digit_idx=0.
  - If the timer reaches 0 in the same cycle as a press, the timeout wins (go to ENTRY).
- PROGRAM:
  - The unlock timer is frozen.
  - Short press: write enc into shadow digit[digit_idx]; digit_idx++.
  - On the CODE_LEN-th digit, the full shadow (including the digit captured that cycle) is committed to the code register in the same edge. Then go to UNLOCKED, reload the timer, digit_idx=0.
  - Long press: abort; code unchanged; go to UNLOCKED, reload the timer, digit_idx=0.
- LOCKOUT:
  - All presses ignored; timer decrements.
  - At 0: fail_cnt=0; go to ENTRY.
  - lockout stays high for exactly LOCKOUT_CYCLES cycles.
- Counter rules:
  - fail_cnt saturates at MAX_FAILS.
  - Timers are sized ceil(log2(max(LOCKOUT_CYCLES,UNLOCK_CYCLES)+1)) bits.
- Encoder value:
  - enc is used as-is; wrap 15->0 is the encoder's concern.
  - A digit value of 0 is legal.
- Reset asserted mid-entry or mid-program:
  - The partial digits and shadow are discarded.
  - The code register returns to DEFAULT_CODE.

Test Plan:
- Reset, then short presses with enc=4,3,2,1 (default 16'h1234 is digits 4,3,2,1 from idx0) -> ok_pulse one cycle after the 4th press; unlocked=1; fail_cnt=0.
- Enter 4,3,2,0 -> err_pulse=1, fail_cnt=1, back in ENTRY. Repeat twice more -> fail_cnt=3, lockout=1 for exactly 1024 cycles; presses ignored; then ENTRY with fail_cnt=0.
- Enter 4,3 then long press, then 4,3,2,1 -> unlock succeeds (partial entry cleared).
- Unlock, long press, short presses with enc=9,8,7,6 -> unlocked=1, prog_mode=0. Relock via short press; 4,3,2,1 -> err_pulse; 9,8,7,6 -> ok_pulse.
- Unlock, long press, enter 5,5, then long press -> code unchanged (4,3,2,1 still unlocks).
- Unlock, no presses for 4096 cycles -> unlocked drops. Also: rstn low mid-PROGRAM -> all outputs 0 and the default code restored.
